// File: rtl/johnson_monitor_if.sv
// Bus bundle between a Johnson-code source and the johnson_monitor decoder.
// The master side drives samples and the error-clear strobe; the slave side
// (the monitor) returns the decoded step, the pulse flags and the lock status.
interface johnson_monitor_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    localparam int SW = $clog2(2 * WIDTH);

    logic             in_valid;
    logic [WIDTH-1:0] johnson_in;
    logic             err_clr;
    logic [SW-1:0]    step;
    logic             step_valid;
    logic             wrap;
    logic             locked;
    logic             seq_err;
    logic [ERR_W-1:0] err_count;

    modport master (
        output in_valid, johnson_in, err_clr,
        input  step, step_valid, wrap, locked, seq_err, err_count
    );

    modport slave (
        input  in_valid, johnson_in, err_clr,
        output step, step_valid, wrap, locked, seq_err, err_count
    );
endinterface

// File: rtl/johnson_monitor.sv
// Johnson-code receive monitor: decodes a sampled Johnson bus to a step index,
// tracks the expected next step, locks after a run of correct transitions and
// flags and counts sequence errors seen while locked.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   UNLOCKED | no reference step; waiting for any legal code
//   ACQUIRE  | reference step held; counting consecutive correct steps
//   LOCKED   | sequence trusted; deviations raise seq_err
module johnson_monitor #(
    parameter int WIDTH      = 4,
    parameter int LOCK_CNT   = 3,
    parameter int ERR_W      = 8,
    parameter int ALLOW_HOLD = 0
) (
    input logic              clk,
    input logic              rst,
    johnson_monitor_if.slave bus
);
    localparam int NSTEPS = 2 * WIDTH;
    localparam int SW     = $clog2(NSTEPS);
    localparam int RW     = $clog2(LOCK_CNT + 1);

    localparam logic [SW-1:0]    LAST_STEP  = SW'(NSTEPS - 1);
    localparam logic [RW-1:0]    RUN_TARGET = RW'(LOCK_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX    = '1;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    step_q, step_d;
    logic [RW-1:0]    run_q, run_d;
    logic [RW-1:0]    run_inc;
    logic             step_valid_q, step_valid_d;
    logic             wrap_q, wrap_d;
    logic             seq_err_q, seq_err_d;
    logic [ERR_W-1:0] err_count_q;

    logic             code_legal;
    logic [SW-1:0]    code_step;
    logic [SW-1:0]    expected_step;
    logic             is_next;
    logic             is_hold;

    // Code for step k: low k bits set up to WIDTH, then low (k-WIDTH) bits clear.
    function automatic logic [WIDTH-1:0] pattern_of(input int k);
        logic [WIDTH-1:0] p;
        for (int b = 0; b < WIDTH; b++) begin
            p[b] = (k <= WIDTH) ? (b < k) : (b >= k - WIDTH);
        end
        return p;
    endfunction

    // Combinational decode of the sampled bus against every legal pattern.
    always_comb begin
        code_legal = 1'b0;
        code_step  = '0;
        for (int k = 0; k < NSTEPS; k++) begin
            if (bus.johnson_in == pattern_of(k)) begin
                code_legal = 1'b1;
                code_step  = SW'(k);
            end
        end
    end

    assign expected_step = (step_q == LAST_STEP) ? '0 : step_q + SW'(1);
    assign is_next       = code_legal && (code_step == expected_step);
    // A repeat of the stored step only counts as a hold when holds are enabled.
    assign is_hold       = (ALLOW_HOLD != 0) && code_legal && (code_step == step_q);
    assign run_inc       = run_q + RW'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UNLOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic together with the stored step and transition run.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        run_d   = run_q;
        if (bus.in_valid) begin
            case (state_q)
                UNLOCKED: begin
                    if (code_legal) begin
                        state_d = ACQUIRE;
                        step_d  = code_step;
                        run_d   = '0;
                    end
                end
                ACQUIRE: begin
                    if (!code_legal) begin
                        state_d = UNLOCKED;
                    end else if (is_next) begin
                        step_d = code_step;
                        run_d  = run_inc;
                        if (run_inc >= RUN_TARGET) begin
                            state_d = LOCKED;
                        end
                    end else if (!is_hold) begin
                        step_d = code_step;
                        run_d  = '0;
                    end
                end
                LOCKED: begin
                    if (!code_legal) begin
                        state_d = UNLOCKED;
                    end else if (is_next) begin
                        step_d = code_step;
                    end else if (!is_hold) begin
                        state_d = ACQUIRE;
                        step_d  = code_step;
                        run_d   = '0;
                    end
                end
                default: begin
                    state_d = UNLOCKED;
                end
            endcase
        end
    end

    // Pulse outputs derived from the current state and the decoded sample.
    always_comb begin
        step_valid_d = 1'b0;
        wrap_d       = 1'b0;
        seq_err_d    = 1'b0;
        if (bus.in_valid) begin
            step_valid_d = code_legal;
            wrap_d       = (state_q != UNLOCKED) && is_next && (code_step == '0);
            seq_err_d    = (state_q == LOCKED) && !is_next && !is_hold;
        end
    end

    // Registered datapath: stored step, run counter, pulses and error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q       <= '0;
            run_q        <= '0;
            step_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
            seq_err_q    <= 1'b0;
            err_count_q  <= '0;
        end else begin
            step_q       <= step_d;
            run_q        <= run_d;
            step_valid_q <= step_valid_d;
            wrap_q       <= wrap_d;
            seq_err_q    <= seq_err_d;
            if (bus.err_clr) begin
                err_count_q <= '0;
            end else if (seq_err_d && (err_count_q != ERR_MAX)) begin
                err_count_q <= err_count_q + ERR_W'(1);
            end
        end
    end

    assign bus.step       = step_q;
    assign bus.step_valid = step_valid_q;
    assign bus.wrap       = wrap_q;
    assign bus.seq_err    = seq_err_q;
    assign bus.err_count  = err_count_q;
    assign bus.locked     = (state_q == LOCKED);
endmodule

// File: tb/tb_johnson_monitor.sv
// Bench for johnson_monitor: two instances (default, and ERR_W=2 with holds
// allowed) share one stimulus stream and are checked against a reference model,
// plus a constant-expectation vector table and hand-written corner sequences.
module tb_johnson_monitor;
    localparam int W      = 4;
    localparam int NSTEPS = 2 * W;
    localparam int LOCKN  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    johnson_monitor_if #(.WIDTH(W), .ERR_W(8)) bus_a ();
    johnson_monitor_if #(.WIDTH(W), .ERR_W(2)) bus_b ();

    johnson_monitor #(.WIDTH(W), .LOCK_CNT(LOCKN), .ERR_W(8), .ALLOW_HOLD(0)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    johnson_monitor #(.WIDTH(W), .LOCK_CNT(LOCKN), .ERR_W(2), .ALLOW_HOLD(1)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int st;     // 0 searching, 1 acquiring, 2 locked
        int last;
        int run;
        bit sv;
        bit wrap;
        bit err;
        int cnt;
    } mstate_t;

    typedef struct {
        bit         v;
        logic [3:0] code;
        bit         clr;
        int         step;
        bit         sv;
        bit         wrap;
        bit         lock;
        bit         err;
        int         cnt;
    } vec_t;

    mstate_t ma, mb;
    vec_t    tbl[24];

    function automatic logic [3:0] code_of(input int k);
        int val;
        if (k <= W) val = (1 << k) - 1;
        else        val = ((1 << W) - 1) - ((1 << (k - W)) - 1);
        return val[3:0];
    endfunction

    function automatic int dec(input logic [3:0] c);
        for (int k = 0; k < NSTEPS; k++) if (code_of(k) == c) return k;
        return -1;
    endfunction

    function automatic mstate_t mreset();
        mstate_t m;
        m.st = 0; m.last = 0; m.run = 0; m.sv = 0; m.wrap = 0; m.err = 0; m.cnt = 0;
        return m;
    endfunction

    function automatic mstate_t mstep(input mstate_t m, input bit v, input logic [3:0] c,
                                      input bit clr, input int errmax, input bit hold);
        mstate_t n;
        int k, nxt;
        n = m; n.sv = 0; n.wrap = 0; n.err = 0;
        if (v) begin
            k   = dec(c);
            nxt = (m.last + 1) % NSTEPS;
            n.sv = (k >= 0);
            if (m.st == 0) begin
                if (k >= 0) begin n.last = k; n.run = 0; n.st = 1; end
            end else if (k < 0) begin
                n.err = (m.st == 2);
                n.st  = 0;
            end else if (k == nxt) begin
                n.wrap = (k == 0);
                n.last = k;
                if (m.st == 1) begin
                    n.run = m.run + 1;
                    if (n.run >= LOCKN) n.st = 2;
                end
            end else if (hold && k == m.last) begin
                // repeat accepted without change
            end else begin
                n.err  = (m.st == 2);
                n.last = k;
                n.run  = 0;
                n.st   = 1;
            end
        end
        if (clr) n.cnt = 0;
        else if (n.err && n.cnt < errmax) n.cnt = n.cnt + 1;
        return n;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model(input string tag, input int step, input int sv, input int wrap,
                             input int lock, input int err, input int cnt, input mstate_t m);
        check({tag, "_step"}, step, m.last);
        check({tag, "_step_valid"}, sv, m.sv);
        check({tag, "_wrap"}, wrap, m.wrap);
        check({tag, "_locked"}, lock, (m.st == 2) ? 1 : 0);
        check({tag, "_seq_err"}, err, m.err);
        check({tag, "_err_count"}, cnt, m.cnt);
    endtask

    task automatic apply(input bit r, input bit v, input logic [3:0] c, input bit clr);
        rst = r;
        bus_a.in_valid = v; bus_a.johnson_in = c; bus_a.err_clr = clr;
        bus_b.in_valid = v; bus_b.johnson_in = c; bus_b.err_clr = clr;
        @(posedge clk);
        #1;
        if (r) begin
            ma = mreset();
            mb = mreset();
        end else begin
            ma = mstep(ma, v, c, clr, 255, 1'b0);
            mb = mstep(mb, v, c, clr, 3, 1'b1);
        end
        cmp_model("a", bus_a.step, bus_a.step_valid, bus_a.wrap, bus_a.locked,
                  bus_a.seq_err, bus_a.err_count, ma);
        cmp_model("b", bus_b.step, bus_b.step_valid, bus_b.wrap, bus_b.locked,
                  bus_b.seq_err, bus_b.err_count, mb);
    endtask

    task automatic feed(input int k);
        apply(1'b0, 1'b1, code_of(k % NSTEPS), 1'b0);
    endtask

    initial begin
        logic [3:0] c;
        bit         v, r, clr;
        int         sel;

        ma = mreset();
        mb = mreset();
        tbl[0]  = '{1'b1, 4'b0011, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b1, 4'b0000, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b1, 4'b0001, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b1, 4'b0011, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[4]  = '{1'b1, 4'b0111, 1'b0, 3, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[5]  = '{1'b0, 4'b0101, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[6]  = '{1'b1, 4'b1111, 1'b0, 4, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[7]  = '{1'b1, 4'b1110, 1'b0, 5, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[8]  = '{1'b1, 4'b1100, 1'b0, 6, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[9]  = '{1'b1, 4'b1000, 1'b0, 7, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[10] = '{1'b1, 4'b0000, 1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        tbl[11] = '{1'b1, 4'b0001, 1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[12] = '{1'b1, 4'b0011, 1'b0, 2, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[13] = '{1'b1, 4'b0111, 1'b0, 3, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[14] = '{1'b1, 4'b1111, 1'b0, 4, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[15] = '{1'b1, 4'b1100, 1'b0, 6, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        tbl[16] = '{1'b1, 4'b1000, 1'b0, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[17] = '{1'b1, 4'b0000, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        tbl[18] = '{1'b1, 4'b0001, 1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        tbl[19] = '{1'b1, 4'b0101, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 2};
        tbl[20] = '{1'b1, 4'b0101, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        tbl[21] = '{1'b1, 4'b0011, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[22] = '{1'b1, 4'b0011, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[23] = '{1'b1, 4'b1011, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0};

        // Initial reset, run into lock, then reset mid-stream for two cycles.
        apply(1'b1, 1'b0, 4'b0000, 1'b0);
        apply(1'b1, 1'b0, 4'b0000, 1'b0);
        for (int k = 0; k < 6; k++) feed(k);
        apply(1'b1, 1'b1, 4'b1110, 1'b1);
        apply(1'b1, 1'b1, 4'b1100, 1'b0);
        check("rst_step",       bus_a.step, 0);
        check("rst_step_valid", bus_a.step_valid, 0);
        check("rst_wrap",       bus_a.wrap, 0);
        check("rst_locked",     bus_a.locked, 0);
        check("rst_seq_err",    bus_a.seq_err, 0);
        check("rst_err_count",  bus_a.err_count, 0);
        check("rst_b_locked",   bus_b.locked, 0);

        // Constant-expectation vector table (default instance).
        for (int i = 0; i < 24; i++) begin
            apply(1'b0, tbl[i].v, tbl[i].code, tbl[i].clr);
            check($sformatf("tbl%0d_step", i),       bus_a.step,       tbl[i].step);
            check($sformatf("tbl%0d_step_valid", i), bus_a.step_valid, tbl[i].sv);
            check($sformatf("tbl%0d_wrap", i),       bus_a.wrap,       tbl[i].wrap);
            check($sformatf("tbl%0d_locked", i),     bus_a.locked,     tbl[i].lock);
            check($sformatf("tbl%0d_seq_err", i),    bus_a.seq_err,    tbl[i].err);
            check($sformatf("tbl%0d_err_count", i),  bus_a.err_count,  tbl[i].cnt);
        end

        // Saturation of the 2-bit counter and err_clr priority.
        apply(1'b1, 1'b0, 4'b0000, 1'b0);
        for (int k = 0; k < 4; k++) feed(k);
        check("b_lock_initial", bus_b.locked, 1);
        for (int i = 1; i <= 5; i++) begin
            apply(1'b0, 1'b1, 4'b0101, 1'b0);
            check($sformatf("b_err%0d_pulse", i), bus_b.seq_err, 1);
            check($sformatf("b_err%0d_count", i), bus_b.err_count, (i < 3) ? i : 3);
            for (int k = 0; k < 4; k++) feed(k);
            check($sformatf("b_relock%0d", i), bus_b.locked, 1);
        end
        apply(1'b0, 1'b1, 4'b0101, 1'b1);
        check("b_clr_pulse", bus_b.seq_err, 1);
        check("b_clr_count", bus_b.err_count, 0);

        // Hold on a repeated code while locked, and no wrap on a held step 0.
        for (int k = 7; k < 11; k++) feed(k);
        check("b_lock_at2", bus_b.locked, 1);
        feed(2);
        check("b_hold_err",    bus_b.seq_err, 0);
        check("b_hold_locked", bus_b.locked, 1);
        check("b_hold_step",   bus_b.step, 2);
        check("b_hold_sv",     bus_b.step_valid, 1);
        for (int k = 3; k < 8; k++) feed(k);
        feed(0);
        check("b_wrap_pulse", bus_b.wrap, 1);
        feed(0);
        check("b_hold0_wrap", bus_b.wrap, 0);
        check("b_hold0_lock", bus_b.locked, 1);

        // Randomized stream against the reference model.
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 199) == 0);
            v   = ($urandom_range(0, 99) < 85);
            clr = ($urandom_range(0, 49) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 6)       c = code_of((ma.last + 1) % NSTEPS);
            else if (sel == 6) c = code_of(ma.last);
            else if (sel == 7) c = code_of($urandom_range(0, NSTEPS - 1));
            else               c = 4'($urandom_range(0, 15));
            apply(r, v, c, clr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
